// File: rtl/ps2_tx.sv
// ps2_tx: host-to-device PS/2 byte transmitter with request-to-send, device-clocked bits and ACK check
module ps2_tx #(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       kbclk_in,
  input  logic       kbdata_in,
  output logic       kbclk_drive,
  output logic       kbdata_drive,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       err
);
  typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SEND, ACK, WAIT_IDLE} state_t;
  state_t state, state_n;
  logic [1:0] cs, ds;
  logic cp, fall, tmo;
  logic [8:0] shreg;
  logic [3:0] cnt;
  logic [31:0] timer;
  assign fall = cp & ~cs[1];
  assign tmo = timer == 32'(TIMEOUT_CYCLES - 1);
  assign tx_ready = state == IDLE;
  assign busy = ~tx_ready;
  // two-flop synchronizers for the pins plus the previous synced clock for edge detection
  always_ff @(posedge clk)
    if (rst) begin
      cs <= 2'b11;
      ds <= 2'b11;
      cp <= 1'b1;
    end else begin
      cs <= {cs[0], kbclk_in};
      ds <= {ds[0], kbdata_in};
      cp <= cs[1];
    end
  // state register, frame shifter {parity, data}, fall counter and phase timer
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
      timer <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE) begin
        cnt   <= '0;
        timer <= '0;
        if (tx_valid) shreg <= {~^tx_data, tx_data};
      end else if (state == INHIBIT || state == REQ) begin
        timer <= (state_n == INHIBIT) ? timer + 32'd1 : '0;
      end else begin
        timer <= fall ? '0 : timer + 32'd1;
        if (state == SEND && fall) begin
          cnt <= cnt + 4'd1;
          if (cnt != 4'd0) shreg <= {1'b1, shreg[8:1]};
        end
      end
    end
  // next state, line drives and end-of-frame pulses; timeout wins over a coincident fall
  always_comb begin
    state_n = state;
    kbclk_drive = 1'b0;
    kbdata_drive = 1'b0;
    done = 1'b0;
    err = 1'b0;
    case (state)
      IDLE: state_n = tx_valid ? INHIBIT : IDLE;
      INHIBIT: begin
        kbclk_drive = 1'b1;
        state_n = (timer == 32'(INHIBIT_CYCLES - 1)) ? REQ : INHIBIT;
      end
      REQ: begin
        kbclk_drive = 1'b1;
        kbdata_drive = 1'b1;
        state_n = SEND;
      end
      SEND: begin
        kbdata_drive = (cnt == 4'd0) | ~shreg[0];
        err = tmo;
        state_n = tmo ? IDLE : (fall && cnt == 4'd9) ? ACK : SEND;
      end
      ACK: begin
        err = tmo | (fall & ds[1]);
        state_n = err ? IDLE : fall ? WAIT_IDLE : ACK;
      end
      WAIT_IDLE: begin
        done = ~tmo & cs[1] & ds[1];
        err = tmo;
        state_n = (tmo | done) ? IDLE : WAIT_IDLE;
      end
      default: state_n = IDLE;
    endcase
    done = done & ~rst;
    err = err & ~rst;
  end
endmodule

// File: tb/tb_ps2_tx.sv
// tb_ps2_tx: randomized scoreboard bench with an open-collector PS/2 device model
module tb_ps2_tx;
  localparam int INH = 20;
  localparam int TMO = 400;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic dev_clk = 1'b1;
  logic dev_dat = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic tx_valid = 1'b0;
  logic kbclk_drive, kbdata_drive, tx_ready, busy, done, err;
  logic kbclk_in, kbdata_in;
  assign kbclk_in = dev_clk & ~kbclk_drive;
  assign kbdata_in = dev_dat & ~kbdata_drive;
  ps2_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .kbclk_in(kbclk_in), .kbdata_in(kbdata_in),
    .kbclk_drive(kbclk_drive), .kbdata_drive(kbdata_drive),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .done(done), .err(err)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int checks = 0;
  int errors = 0;
  typedef struct {
    bit is_err;
    bit chk_bits;
    bit chk_time;
    logic [10:0] bits;
  } exp_t;
  exp_t q[$];
  exp_t me;
  logic [10:0] obs_bits = '0;
  int obs_hold = 0;
  int last_drop = 0;
  int end_cyc = 0;
  int acc_cyc = 0;
  bit post = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor: pops the expected outcome whenever the DUT ends a frame
  always @(negedge clk) begin
    if (post) begin
      chk("post_ready", 32'(tx_ready), 1);
      chk("post_drives", 32'({kbclk_drive, kbdata_drive}), 0);
    end
    post <= 1'b0;
    if (done || err) begin
      end_cyc <= cyc;
      post <= 1'b1;
      chk("done_err_excl", 32'(done & err), 0);
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: done=%0b err=%0b with no frame outstanding", done, err);
      end else begin
        me = q.pop_front();
        chk("outcome_err", 32'(err), 32'(me.is_err));
        if (me.chk_bits) begin
          chk("frame_bits", 32'(obs_bits), 32'(me.bits));
          chk("clk_hold", obs_hold, INH + 1);
        end
        if (me.chk_time) chk("timeout_cycle", cyc, last_drop + 2 + TMO);
      end
    end
  end

  // device: mode 0 ack, 1 nack, 2 stall after fall 4, 3 stop mid-frame for reset
  task automatic dev_frame(input int mode, input bit pk);
    int n;
    @(negedge clk);
    n = 0;
    while (kbclk_drive && n < 1000) begin
      n++;
      @(negedge clk);
    end
    obs_hold = n;
    obs_bits = '0;
    obs_bits[0] = kbdata_in;
    repeat (10) @(negedge clk);
    for (int k = 1; k <= 10; k++) begin
      if (mode == 2 && k == 5) return;
      dev_clk = 1'b0;
      last_drop = cyc;
      repeat (20) @(negedge clk);
      if (pk && k == 3) begin
        tx_data = 8'h55;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
      end
      if (mode == 3 && k == 5) return;
      dev_clk = 1'b1;
      obs_bits[k] = kbdata_in;
      repeat (20) @(negedge clk);
    end
    if (mode == 0) dev_dat = 1'b0;
    repeat (10) @(negedge clk);
    dev_clk = 1'b0;
    repeat (20) @(negedge clk);
    dev_clk = 1'b1;
    repeat (5) @(negedge clk);
    dev_dat = 1'b1;
  endtask

  task automatic send(input logic [7:0] d, input int mode, input bit pk, input bit b2b);
    exp_t e;
    int n;
    e.is_err = (mode == 1) || (mode == 2);
    e.chk_bits = mode <= 1;
    e.chk_time = mode == 2;
    e.bits = {1'b1, ($countones(d) % 2 == 0) ? 1'b1 : 1'b0, d, 1'b0};
    if (mode != 3) q.push_back(e);
    tx_data = d;
    tx_valid = 1'b1;
    n = 0;
    while (!tx_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!tx_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_wait: tx_ready still %0b after %0d cycles", tx_ready, n);
    end
    acc_cyc = cyc;
    if (b2b) chk("b2b_accept_cycle", acc_cyc, end_cyc + 1);
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    tx_data = 8'($urandom);
    dev_frame(mode, pk);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL frame_end_wait: %0d outcomes outstanding, expected 0", q.size());
      q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_drives", 32'({kbclk_drive, kbdata_drive}), 0);
    chk("rst_ready_busy", 32'({tx_ready, busy}), 32'b10);
    chk("rst_done_err", 32'({done, err}), 0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      dev_clk = 1'b0;
      repeat (8) @(negedge clk);
      chk("idle_fall_drives", 32'({kbclk_drive, kbdata_drive}), 0);
      chk("idle_fall_ready", 32'(tx_ready), 1);
      dev_clk = 1'b1;
      repeat (8) @(negedge clk);
    end
    send(8'hED, 0, 1'b0, 1'b0);
    drain();
    send(8'h00, 0, 1'b0, 1'b0);
    send(8'h01, 0, 1'b0, 1'b1);
    drain();
    send(8'hA5, 1, 1'b0, 1'b0);
    drain();
    send(8'($urandom), 2, 1'b0, 1'b0);
    drain();
    send(8'h3C, 0, 1'b1, 1'b0);
    drain();
    send(8'($urandom), 3, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_drives", 32'({kbclk_drive, kbdata_drive}), 0);
    chk("midrst_ready_busy", 32'({tx_ready, busy}), 32'b10);
    rst = 1'b0;
    dev_clk = 1'b1;
    repeat (10) @(negedge clk);
    send(8'hFF, 0, 1'b0, 1'b0);
    drain();
    for (int i = 0; i < 8; i++) begin
      send(8'($urandom), ($urandom_range(0, 3) == 0) ? 1 : 0, 1'b0, 1'b0);
      drain();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
